// File: rtl/aline_receive_fsm.sv
// A-line receive sequencer: blanks transmit feedthrough, captures ADC echo samples into an
// internal RAM, then drains them to the UART as a framed byte stream:
// 0xA5, {4'h0, aline_id}, then {hi, lo} per sample.
module aline_receive_fsm #(
    parameter int unsigned ADC_WIDTH = 12,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture_start,
    input  logic [3:0]           aline_id,
    input  logic [ADDR_W:0]      num_samples,
    input  logic [15:0]          blank_cycles,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 mem_clear,
    output logic                 busy,
    output logic                 start_overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StBlank,
        StCapture,
        StHeader,
        StId,
        StFetch,
        StSendHi,
        StSendLo
    } state_e;

    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);

    state_e                state_q, state_d;
    logic [3:0]            id_q, id_d;
    logic [ADDR_W:0]       num_q, num_d;
    logic [15:0]           blank_q, blank_d;
    // Pointers carry one extra bit so a full DEPTH-sample count is representable.
    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       wr_ptr_inc, rd_ptr_inc, num_clamped;
    logic                  wr_en, rd_en;
    logic [ADC_WIDTH-1:0]  rd_data_q;
    logic [15:0]           sample_ext;
    logic                  busy_q, mem_clear_q, overrun_q;

    logic [ADC_WIDTH-1:0]  mem [DEPTH];

    assign num_clamped = (num_samples > DepthW) ? DepthW : num_samples;
    assign wr_ptr_inc  = wr_ptr_q + PtrOne;
    assign rd_ptr_inc  = rd_ptr_q + PtrOne;
    assign sample_ext  = 16'(rd_data_q);

    // Next-state, datapath controls and byte presentation
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        num_d    = num_q;
        blank_d  = blank_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (capture_start) begin
                    id_d    = aline_id;
                    num_d   = num_clamped;
                    blank_d = blank_cycles;
                    // A zero blank length skips BLANK so storage can start on the next cycle.
                    if (blank_cycles != 16'd0) begin
                        state_d = StBlank;
                    end else if (num_clamped == '0) begin
                        state_d = StHeader;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StBlank: begin
                blank_d = blank_q - 16'd1;
                if (blank_q == 16'd1) begin
                    state_d = (num_q == '0) ? StHeader : StCapture;
                end
            end
            StCapture: begin
                if (adc_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    if (wr_ptr_inc == num_q) begin
                        state_d = StHeader;
                    end
                end
            end
            StHeader: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA5;
                if (tx_ready) begin
                    state_d = StId;
                end
            end
            StId: begin
                tx_valid = 1'b1;
                tx_data  = {4'h0, id_q};
                if (tx_ready) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (rd_ptr_q == num_q) begin
                    state_d = StIdle;
                end else begin
                    rd_en   = 1'b1;
                    state_d = StSendHi;
                end
            end
            StSendHi: begin
                tx_valid = 1'b1;
                tx_data  = sample_ext[15:8];
                if (tx_ready) begin
                    state_d = StSendLo;
                end
            end
            StSendLo: begin
                tx_valid = 1'b1;
                tx_data  = sample_ext[7:0];
                if (tx_ready) begin
                    rd_ptr_d = rd_ptr_inc;
                    state_d  = (rd_ptr_inc == num_q) ? StIdle : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // State, latched parameters, pointers and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            id_q        <= 4'h0;
            num_q       <= '0;
            blank_q     <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            busy_q      <= 1'b0;
            mem_clear_q <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            num_q       <= num_d;
            blank_q     <= blank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            busy_q      <= (state_d != StIdle);
            mem_clear_q <= (state_d == StIdle);
            if (capture_start && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Sample buffer: synchronous write during CAPTURE, synchronous read issued from FETCH
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= adc_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    assign busy          = busy_q;
    assign mem_clear     = mem_clear_q;
    assign start_overrun = overrun_q;

endmodule

// File: tb/tb_aline_receive_fsm.sv
// Bench for aline_receive_fsm: a per-cycle frame model plus literal frame expectations.
module tb_aline_receive_fsm;

    localparam int ADC_WIDTH = 12;
    localparam int DEPTH     = 1024;
    localparam int ADDR_W    = 10;

    localparam int ModeTbl  = 0;
    localparam int ModeRamp = 1;
    localparam int ModeOvr  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 capture_start;
    logic [3:0]           aline_id;
    logic [ADDR_W:0]      num_samples;
    logic [15:0]          blank_cycles;
    logic [ADC_WIDTH-1:0] adc_data;
    logic                 adc_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 mem_clear;
    logic                 busy;
    logic                 start_overrun;

    always #5 clk = ~clk;

    aline_receive_fsm #(
        .ADC_WIDTH (ADC_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .capture_start (capture_start),
        .aline_id      (aline_id),
        .num_samples   (num_samples),
        .blank_cycles  (blank_cycles),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .mem_clear     (mem_clear),
        .busy          (busy),
        .start_overrun (start_overrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: phase 0 idle, 1 blanking/capturing, 2 draining frame, 3 empty-fetch tail.
    int              phase = 0;
    int              k_cyc;
    int              m_blank;
    int              m_n;
    logic [3:0]      m_id;
    logic [11:0]     samples[$];
    logic [7:0]      exp_q[$];
    logic [7:0]      got[$];
    logic            exp_busy = 1'b0;
    logic            exp_ovr  = 1'b0;
    logic            hdr_due  = 1'b0;
    logic            prev_stall = 1'b0;
    logic [7:0]      prev_data  = 8'h00;
    int              rdy_mode   = 0;

    logic [11:0]     tbl[4] = '{12'h123, 12'h456, 12'h789, 12'hABC};

    function automatic void build_frame();
        logic [15:0] ext;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back({4'h0, m_id});
        foreach (samples[i]) begin
            ext = 16'(samples[i]);
            exp_q.push_back(ext[15:8]);
            exp_q.push_back(ext[7:0]);
        end
    endfunction

    // Compare process: checks outputs of the current cycle, then advances the model.
    initial begin : monitor
        int ph;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ph = phase;
            check("busy", 32'(busy), 32'(exp_busy));
            check("mem_clear", 32'(mem_clear), 32'(!exp_busy));
            check("start_overrun", 32'(start_overrun), 32'(exp_ovr));
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (ph == 1) check("valid_low_capture", 32'(tx_valid), 32'd0);
            if (hdr_due) begin
                check("hdr_valid", 32'(tx_valid), 32'd1);
                check("hdr_data", 32'(tx_data), 32'hA5);
            end
            hdr_due = 1'b0;
            if (rst) begin
                phase    = 0;
                exp_busy = 1'b0;
                exp_ovr  = 1'b0;
                exp_q.delete();
            end else begin
                if (tx_valid && tx_ready) begin
                    got.push_back(tx_data);
                    if (ph == 2 && exp_q.size() > 0) begin
                        check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                        if (exp_q.size() == 0) begin
                            if (m_n > 0) begin
                                phase    = 0;
                                exp_busy = 1'b0;
                            end else begin
                                phase = 3;
                            end
                        end
                    end else begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got %0h expected no transfer", tx_data);
                    end
                end
                if (capture_start && ph != 0) exp_ovr = 1'b1;
                case (ph)
                    0: if (capture_start) begin
                        m_id    = aline_id;
                        m_blank = int'(blank_cycles);
                        m_n     = (int'(num_samples) > DEPTH) ? DEPTH : int'(num_samples);
                        k_cyc   = 0;
                        samples.delete();
                        exp_busy = 1'b1;
                        if (m_n == 0 && m_blank == 0) begin
                            build_frame();
                            phase   = 2;
                            hdr_due = 1'b1;
                        end else begin
                            phase = 1;
                        end
                    end
                    1: begin
                        k_cyc++;
                        if (m_n == 0) begin
                            if (k_cyc == m_blank) begin
                                build_frame();
                                phase   = 2;
                                hdr_due = 1'b1;
                            end
                        end else if (k_cyc >= m_blank + 1 && adc_valid) begin
                            samples.push_back(adc_data);
                            if (samples.size() == m_n) begin
                                build_frame();
                                phase   = 2;
                                hdr_due = 1'b1;
                            end
                        end
                    end
                    3: begin
                        phase    = 0;
                        exp_busy = 1'b0;
                    end
                    default: ;
                endcase
            end
            prev_stall = tx_valid && !tx_ready && !rst;
            prev_data  = tx_data;
        end
    end

    // UART ready: tied high or randomly toggling
    initial begin : ready_drv
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_adc(input int mode, input int k, input int blank);
        adc_valid = 1'b1;
        if (mode == ModeRamp) begin
            adc_data = 12'(k);
        end else if (k >= blank + 1 && k - blank - 1 < 4) begin
            adc_data = tbl[k - blank - 1];
        end else begin
            adc_data = 12'hFFF;
        end
    endtask

    task automatic run_capture(input logic [3:0] id, input logic [10:0] num,
                               input logic [15:0] blank, input int mode);
        int k;
        @(posedge clk);
        #1;
        got.delete();
        capture_start = 1'b1;
        aline_id      = id;
        num_samples   = num;
        blank_cycles  = blank;
        drive_adc(mode, 0, int'(blank));
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) check("mem_clear_drop", 32'(mem_clear), 32'd0);
            capture_start = (mode == ModeOvr) && (k == int'(blank) + 2);
            drive_adc(mode, k, int'(blank));
        end while (phase == 1 && k < 5000);
        capture_start = 1'b0;
        adc_valid     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (phase != 0 && n < 10000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_done", 32'(phase == 0), 32'd1);
        @(posedge clk);
        #1;
        check("idle_mem_clear", 32'(mem_clear), 32'd1);
    endtask

    task automatic check_got(input string name, input logic [7:0] e[$]);
        check({name, "_len"}, 32'(got.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            check($sformatf("%s_b%0d", name, i), 32'(got[i]), 32'(e[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] basic_exp[$];
    logic [7:0] blank_exp[$];

    initial begin : stim
        int n;
        basic_exp = '{8'hA5, 8'h03, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC};
        blank_exp = '{8'hA5, 8'h01, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08};
        rst           = 1'b1;
        capture_start = 1'b0;
        aline_id      = 4'h0;
        num_samples   = '0;
        blank_cycles  = 16'd0;
        adc_data      = '0;
        adc_valid     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_mem_clear", 32'(mem_clear), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(start_overrun), 32'd0);
        rst = 1'b0;

        // Basic frame
        run_capture(4'd3, 11'd4, 16'd2, ModeTbl);
        wait_idle();
        check_got("basic", basic_exp);

        // Blanking: ramp from capture_start, first stored value is 6
        run_capture(4'd1, 11'd3, 16'd5, ModeRamp);
        wait_idle();
        check_got("blank", blank_exp);

        // Backpressure
        rdy_mode = 1;
        run_capture(4'd3, 11'd4, 16'd2, ModeTbl);
        wait_idle();
        check_got("bp", basic_exp);
        rdy_mode = 0;

        // Zero samples, with and without blanking
        run_capture(4'd9, 11'd0, 16'd0, ModeTbl);
        wait_idle();
        check_got("zero_nb", '{8'hA5, 8'h09});
        run_capture(4'd2, 11'd0, 16'd3, ModeTbl);
        wait_idle();
        check_got("zero_b", '{8'hA5, 8'h02});

        // Oversized request clamps to DEPTH
        run_capture(4'd7, 11'd2000, 16'd1, ModeRamp);
        wait_idle();
        check("clamp_len", 32'(got.size()), 32'd2050);
        if (got.size() == 2050) begin
            check("clamp_first_hi", 32'(got[2]), 32'h00);
            check("clamp_first_lo", 32'(got[3]), 32'h02);
            check("clamp_last_hi", 32'(got[2048]), 32'h04);
            check("clamp_last_lo", 32'(got[2049]), 32'h01);
        end

        // Overrun during CAPTURE
        run_capture(4'd3, 11'd4, 16'd2, ModeOvr);
        wait_idle();
        check_got("ovr", basic_exp);
        check("ovr_flag", 32'(start_overrun), 32'd1);
        run_capture(4'd5, 11'd1, 16'd0, ModeRamp);
        wait_idle();
        check("ovr_sticky", 32'(start_overrun), 32'd1);
        do_reset();
        check("ovr_cleared", 32'(start_overrun), 32'd0);

        // Reset mid-drain after the 5th byte
        run_capture(4'd3, 11'd4, 16'd2, ModeTbl);
        n = 0;
        while (got.size() < 5 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_5th", 32'(got.size() >= 5), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_mem_clear", 32'(mem_clear), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        run_capture(4'd3, 11'd4, 16'd2, ModeTbl);
        wait_idle();
        check_got("post_rst", basic_exp);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aline_receive_fsm.md
# aline_receive_fsm

Receive-side counterpart of the A-line transmit sequencer. The block captures the echo samples for one A-line from the AFE ADC after the transmit burst, blanking the first samples to ignore transmit feedthrough. It buffers the samples in an internal RAM and drains them as a framed byte stream to the UART transmitter. It drives `mem_clear` high only when the buffer is empty and idle; the transmit sequencer waits on that signal before firing the next A-line.

## Interface
- `ADC_WIDTH`, 12: ADC sample width; legal range 9..16.
- `DEPTH`, 1024: sample buffer depth; power of two.
- `ADDR_W`, 10: log2(`DEPTH`).
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `capture_start`  in  1  one-cycle pulse when the A-line transmit completes; starts a capture.
- `aline_id`  in  4  A-line number; sampled with `capture_start`.
- `num_samples`  in  ADDR_W+1  samples to store; sampled with `capture_start`.
- `blank_cycles`  in  16  clk cycles to ignore after start; sampled with `capture_start`.
- `adc_data`  in  ADC_WIDTH  ADC sample.
- `adc_valid`  in  1  `adc_data` is valid this cycle.
- `tx_data`  out  8  byte to the UART.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  the UART accepts the byte.
- `mem_clear`  out  1  buffer empty and block idle.
- `busy`  out  1  block is in any state other than IDLE.
- `start_overrun`  out  1  sticky: `capture_start` arrived while busy.

## Operation
- States: IDLE, BLANK, CAPTURE, HEADER, ID, FETCH, SEND_HI, SEND_LO.
- IDLE:
  - `mem_clear`=1, `busy`=0.
  - On `capture_start`, latch `aline_id`, `blank_cycles` and `num_samples`, then go to BLANK.
  - `num_samples` > `DEPTH` is clamped to `DEPTH`.
- BLANK:
  - The counter counts clk cycles, not valid samples.
  - Leave for CAPTURE after exactly `blank_cycles` cycles; 0 means CAPTURE on the next cycle.
  - `adc_valid` is ignored here.
- CAPTURE:
  - Each `adc_valid` cycle writes `adc_data` to RAM[wr_ptr] and increments wr_ptr.
  - After `num_samples` writes, go to HEADER.
  - If `num_samples`=0, go to HEADER straight from BLANK's exit without writing.
- HEADER: present 0xA5; advance on handshake.
- ID: present {4'h0, latched aline_id}; advance on handshake.
- FETCH:
  - One cycle for the synchronous RAM read of RAM[rd_ptr]; then go to SEND_HI.
  - If zero samples remain, return to IDLE instead.
- SEND_HI:
  - Present the sample's upper bits zero-extended to 8: {(16-ADC_WIDTH) zeros, sample}[15:8].
  - Advance to SEND_LO on handshake.
- SEND_LO:
  - Present sample[7:0].
  - On handshake, increment rd_ptr. Go to FETCH if samples remain, else IDLE.
- Returning to IDLE resets wr_ptr and rd_ptr to 0 and raises `mem_clear`.
- `capture_start` outside IDLE is ignored and sets `start_overrun`; only `rst` clears it.

## Timing
- Reset values: state IDLE, `tx_valid`=0, `tx_data`=0, `mem_clear`=1, `busy`=0, `start_overrun`=0, both pointers 0.
- `rst` asserted mid-capture or mid-drain:
  - Abort next cycle; no partial frame continues.
  - `mem_clear`=1 on the first cycle after reset.
- `mem_clear` and `busy` are registered.
  - Both change on the cycle after `capture_start`.
  - `mem_clear` returns high on the cycle after the last SEND_LO handshake.
- Byte handshake is valid/ready:
  - A transfer occurs on a posedge with `tx_valid` & `tx_ready`.
  - `tx_data` stays stable while `tx_valid` is high and not accepted.
  - `tx_valid` never drops without a transfer, except on `rst`.
- `tx_valid` is low in IDLE, BLANK, CAPTURE and FETCH.
- Latency:
  - First ADC write is possible `blank_cycles`+1 cycles after `capture_start`.
  - HEADER is valid the cycle after the final write.
  - Each sample costs 3 cycles minimum (FETCH plus two bytes) with `tx_ready` tied high.
- Frame length is 2 + 2·N bytes.
- A sample present on the exact cycle BLANK exits is not stored; storage begins the following cycle.

## Test plan
- **Basic frame.** ADC_WIDTH=12, start with aline_id=3, num_samples=4, blank_cycles=2; adc_valid constant, data 0x123, 0x456, 0x789, 0xABC after blanking; tx_ready=1.
  - Required bytes: A5 03 01 23 04 56 07 89 0A BC.
  - `mem_clear` goes low→high around the frame.
- **Blanking.** blank_cycles=5; ramp data 0,1,2,… every cycle from `capture_start`.
  - The first stored sample equals the ramp value one cycle after BLANK exits (value 6).
  - Count cycles exactly.
- **Backpressure.** Same stimulus as the basic frame, with tx_ready toggling 1-0-0-1 randomly.
  - Identical byte sequence.
  - `tx_data` stable across every stalled cycle.
- **Boundaries.**
  - num_samples=0: output A5, ID byte only, then IDLE.
  - num_samples=2000 with DEPTH=1024: exactly 1024 samples and 2050 bytes.
- **Overrun.** Pulse `capture_start` during CAPTURE.
  - `start_overrun`=1.
  - The frame is unaffected.
  - The flag stays high until `rst`.
- **Reset mid-drain.** Assert `rst` after the 5th byte.
  - Next cycle: `tx_valid`=0, `mem_clear`=1, `busy`=0.
  - A new capture produces a clean frame starting with A5.
